// File: rtl/change_pkg.sv
// change_pkg: shared payout FSM states, denomination values and one-hot coin codes.
package change_pkg;
    typedef enum logic [2:0] {IDLE, SELECT, OFFER, DONE, FAULT} state_t;
    localparam int VAL0 = 1;
    localparam int VAL1 = 5;
    localparam int VAL2 = 10;
    localparam int VAL3 = 20;
    localparam logic [3:0] COIN_1  = 4'b0001;
    localparam logic [3:0] COIN_5  = 4'b0010;
    localparam logic [3:0] COIN_10 = 4'b0100;
    localparam logic [3:0] COIN_20 = 4'b1000;
endpackage

// File: rtl/change_denom_select.sv
// change_denom_select: greedy pick of the largest non-empty coin that fits the remaining amount.
module change_denom_select
    import change_pkg::*;
#(
    parameter int W    = 7,
    parameter int VAL0 = change_pkg::VAL0,
    parameter int VAL1 = change_pkg::VAL1,
    parameter int VAL2 = change_pkg::VAL2,
    parameter int VAL3 = change_pkg::VAL3
) (
    input  logic [W-1:0] remaining,
    input  logic [3:0]   coin_empty,
    output logic [3:0]   sel_onehot,
    output logic [W-1:0] sel_value,
    output logic         none_ok
);
    localparam logic [W-1:0] V0 = W'(VAL0);
    localparam logic [W-1:0] V1 = W'(VAL1);
    localparam logic [W-1:0] V2 = W'(VAL2);
    localparam logic [W-1:0] V3 = W'(VAL3);
    logic [3:0] ok;
    always_comb begin
        ok = {!coin_empty[3] && remaining >= V3, !coin_empty[2] && remaining >= V2,
              !coin_empty[1] && remaining >= V1, !coin_empty[0] && remaining >= V0};
        sel_onehot = ok[3] ? COIN_20 : ok[2] ? COIN_10 : ok[1] ? COIN_5 : ok[0] ? COIN_1 : 4'b0000;
        sel_value  = ok[3] ? V3 : ok[2] ? V2 : ok[1] ? V1 : ok[0] ? V0 : '0;
        none_ok    = ~|ok;
    end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time over a valid/ack hopper handshake.
module change_dispenser
    import change_pkg::*;
#(
    parameter int W       = 7,
    parameter int VAL0    = change_pkg::VAL0,
    parameter int VAL1    = change_pkg::VAL1,
    parameter int VAL2    = change_pkg::VAL2,
    parameter int VAL3    = change_pkg::VAL3,
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] amount,
    input  logic [3:0]   coin_empty,
    input  logic         coin_ack,
    input  logic         clr_fault,
    output logic         busy,
    output logic         coin_valid,
    output logic [3:0]   coin_sel,
    output logic         done,
    output logic         fault,
    output logic [W-1:0] remaining,
    output logic [W-1:0] coin_count
);
    state_t state, state_n;
    logic [3:0] pick, sel;
    logic [W-1:0] pick_val, val;
    logic none_ok, timeout;
    logic [TW-1:0] timer;

    change_denom_select #(.W(W), .VAL0(VAL0), .VAL1(VAL1), .VAL2(VAL2), .VAL3(VAL3)) u_sel (
        .remaining (remaining),
        .coin_empty(coin_empty),
        .sel_onehot(pick),
        .sel_value (pick_val),
        .none_ok   (none_ok)
    );

    assign timeout = timer == TW'(TIMEOUT - 1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SELECT : IDLE;
            SELECT:  state_n = remaining == '0 ? DONE : none_ok ? FAULT : OFFER;
            OFFER:   state_n = coin_ack ? SELECT : timeout ? FAULT : OFFER;
            DONE:    state_n = IDLE;
            FAULT:   state_n = clr_fault ? IDLE : FAULT;
            default: state_n = IDLE;
        endcase
    end

    // The chosen coin is latched in SELECT so tube changes during OFFER cannot withdraw it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            remaining  <= '0;
            coin_count <= '0;
            timer      <= '0;
            sel        <= '0;
            val        <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                remaining  <= amount;
                coin_count <= '0;
            end
            if (state == SELECT) begin
                timer <= '0;
                sel   <= pick;
                val   <= pick_val;
            end
            if (state == OFFER) begin
                if (coin_ack) begin
                    remaining  <= remaining - val;
                    coin_count <= coin_count + W'(1);
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

    assign busy       = state != IDLE;
    assign coin_valid = state == OFFER;
    assign coin_sel   = state == OFFER ? sel : 4'b0000;
    assign done       = state == DONE;
    assign fault      = state == FAULT;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed payout scenarios checked with immediate assertions.
module tb_change_dispenser;
    localparam int W  = 7;
    localparam int TO = 1000;

    logic clk = 0;
    logic rst = 0;
    logic start = 0;
    logic [W-1:0] amount = '0;
    logic [3:0] coin_empty = '0;
    logic coin_ack = 0;
    logic clr_fault = 0;
    logic busy, coin_valid, done, fault;
    logic [3:0] coin_sel;
    logic [W-1:0] remaining, coin_count;

    int vectors = 0;
    int errors = 0;
    int cyc, done_cyc, done_cnt, offer_cycles, age, ack_delay;
    logic prev_valid;
    logic [3:0] seq[$];

    change_dispenser #(.W(W), .TIMEOUT(TO), .TW(10)) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount), .coin_empty(coin_empty),
        .coin_ack(coin_ack), .clr_fault(clr_fault), .busy(busy), .coin_valid(coin_valid),
        .coin_sel(coin_sel), .done(done), .fault(fault), .remaining(remaining),
        .coin_count(coin_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; records offers/done and drives ack after ack_delay OFFER cycles (-1 = never).
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (coin_valid && !prev_valid) begin
            seq.push_back(coin_sel);
            age = 0;
        end
        if (coin_valid) offer_cycles++;
        coin_ack = coin_valid && ack_delay >= 0 && age >= ack_delay;
        if (coin_valid) age++;
        prev_valid = coin_valid;
    endtask

    task automatic begin_pay(input logic [W-1:0] amt, input int dly);
        seq.delete();
        cyc = -1;
        done_cyc = -1;
        done_cnt = 0;
        offer_cycles = 0;
        age = 0;
        prev_valid = 0;
        ack_delay = dly;
        amount = amt;
        start = 1;
        step();
        start = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_valid"}, 32'(coin_valid), 0);
        chk({tag, "_sel"}, 32'(coin_sel), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_rem"}, 32'(remaining), 0);
        chk({tag, "_cnt"}, 32'(coin_count), 0);
    endtask

    initial begin
        ack_delay = -1;
        prev_valid = 0;
        cyc = 0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1;
        step();

        // 37 = 20+10+5+1+1, ack immediate
        begin_pay(37, 0);
        while (cyc < 14) step();
        chk("t37_ncoins", seq.size(), 5);
        if (seq.size() == 5) begin
            chk("t37_c0", 32'(seq[0]), 32'b1000);
            chk("t37_c1", 32'(seq[1]), 32'b0100);
            chk("t37_c2", 32'(seq[2]), 32'b0010);
            chk("t37_c3", 32'(seq[3]), 32'b0001);
            chk("t37_c4", 32'(seq[4]), 32'b0001);
        end
        chk("t37_cnt", 32'(coin_count), 5);
        chk("t37_rem", 32'(remaining), 0);
        chk("t37_done_cyc", 32'(done_cyc), 11);
        chk("t37_done_cnt", 32'(done_cnt), 1);
        chk("t37_idle", 32'(busy), 0);

        // 25 with 10s empty -> 20, 5
        coin_empty = 4'b0100;
        begin_pay(25, 0);
        while (cyc < 8) step();
        chk("t25_ncoins", seq.size(), 2);
        if (seq.size() == 2) begin
            chk("t25_c0", 32'(seq[0]), 32'b1000);
            chk("t25_c1", 32'(seq[1]), 32'b0010);
        end
        chk("t25_cnt", 32'(coin_count), 2);
        chk("t25_done_cyc", 32'(done_cyc), 5);
        chk("t25_done_cnt", 32'(done_cnt), 1);

        // 3 with 1s empty -> immediate fault, start ignored, clr_fault recovers
        coin_empty = 4'b0001;
        begin_pay(3, 0);
        while (cyc < 3) step();
        chk("t3_fault", 32'(fault), 1);
        chk("t3_busy", 32'(busy), 1);
        chk("t3_rem", 32'(remaining), 3);
        chk("t3_ncoins", seq.size(), 0);
        amount = 9;
        start = 1;
        step();
        start = 0;
        step();
        chk("t3_start_ign_fault", 32'(fault), 1);
        chk("t3_start_ign_rem", 32'(remaining), 3);
        clr_fault = 1;
        step();
        clr_fault = 0;
        chk("t3_clr_fault", 32'(fault), 0);
        chk("t3_clr_busy", 32'(busy), 0);
        coin_empty = 4'b0000;

        // 20, no ack -> timeout after exactly TO offer cycles
        begin_pay(20, -1);
        while (!fault && cyc < TO + 50) step();
        chk("tto_fault", 32'(fault), 1);
        chk("tto_offer_cycles", 32'(offer_cycles), TO);
        chk("tto_rem", 32'(remaining), 20);
        chk("tto_cnt", 32'(coin_count), 0);
        clr_fault = 1;
        step();
        clr_fault = 0;

        // 20, ack on the last allowed cycle -> no fault
        begin_pay(20, TO - 1);
        while (done_cnt == 0 && !fault && cyc < TO + 50) step();
        chk("tlast_fault", 32'(fault), 0);
        chk("tlast_done", 32'(done_cnt), 1);
        chk("tlast_rem", 32'(remaining), 0);
        chk("tlast_offer_cycles", 32'(offer_cycles), TO);
        step();

        // 12, slow ack, extra start mid-payout, 1s run out during the 1-coin offer
        begin_pay(12, 3);
        while (!fault && cyc < 60) begin
            start = cyc == 3;
            if (coin_valid && coin_sel == 4'b0001) coin_empty[0] = 1'b1;
            step();
        end
        start = 0;
        chk("t12_ncoins", seq.size(), 2);
        if (seq.size() == 2) begin
            chk("t12_c0", 32'(seq[0]), 32'b0100);
            chk("t12_c1", 32'(seq[1]), 32'b0001);
        end
        chk("t12_fault", 32'(fault), 1);
        chk("t12_rem", 32'(remaining), 1);
        chk("t12_cnt", 32'(coin_count), 2);
        chk("t12_done_cnt", 32'(done_cnt), 0);
        clr_fault = 1;
        step();
        clr_fault = 0;
        coin_empty = 4'b0000;

        // reset during OFFER of 30, then a normal 5
        begin_pay(30, -1);
        while (!coin_valid && cyc < 10) step();
        chk("trst_offer", 32'(coin_valid), 1);
        step();
        rst = 0;
        step();
        check_reset_outputs("trst");
        rst = 1;
        begin_pay(5, 0);
        while (cyc < 8) step();
        chk("t5_ncoins", seq.size(), 1);
        if (seq.size() == 1) chk("t5_c0", 32'(seq[0]), 32'b0010);
        chk("t5_cnt", 32'(coin_count), 1);
        chk("t5_rem", 32'(remaining), 0);
        chk("t5_done_cnt", 32'(done_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
